// File: rtl/ffdiv_share_pkg.sv
// Shared definitions for the divider-sharing controller: FSM encoding,
// the quiet-NaN returned on timeout, and IEEE-754 field packing.
package ffdiv_share_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_BUSY  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

  function automatic logic [31:0] f_pack(input logic        sign,
                                         input logic [7:0]  exp,
                                         input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/ffdiv_rr_arb.sv
// Combinational round-robin arbiter: grants the first set request found
// when searching upward from ptr+1, wrapping around.
module ffdiv_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int              k;
    logic [IDX_W-1:0] idx;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = 0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k   = (int'(ptr) + i) % NUM_REQ;
      idx = IDX_W'(k);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ffdiv_share_ctrl.sv
// Shares one iterative single-precision divider among NUM_REQ requesters:
// round-robin issue, held start, timeout abort, one-cycle divider clear between ops.
module ffdiv_share_ctrl
  import ffdiv_share_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int OPERAND_WIDTH     = 32,
  parameter int EXP_WIDTH         = 8,
  parameter int SIGNIFICAND_WIDTH = 24,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int CYC_WIDTH         = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_op_1,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_op_2,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic [OPERAND_WIDTH-1:0]           rsp_result,
  output logic [CYC_WIDTH-1:0]               rsp_cycles,
  output logic                               rsp_err,
  output logic [OPERAND_WIDTH-1:0]           div_op_1,
  output logic [OPERAND_WIDTH-1:0]           div_op_2,
  output logic                               div_start,
  output logic                               div_clr_n,
  input  logic                               div_sign,
  input  logic [EXP_WIDTH-1:0]               div_biased_exp,
  input  logic [SIGNIFICAND_WIDTH-2:0]       div_fraction,
  input  logic                               div_ready,
  input  logic [$clog2(OPERAND_WIDTH)-1:0]   div_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t                state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [CYC_WIDTH-1:0]  cnt_q;
  logic                  div_start_q;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [CYC_WIDTH-1:0]  cnt_inc;
  logic                  timeout_hit;

  // div_count is a debug tap only.
  logic unused_div_count;
  assign unused_div_count = ^div_count;

  ffdiv_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign req_ready   = (state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid   = (state_q == ST_RESP);
  assign div_clr_n   = (state_q != ST_CLEAR);
  assign div_start   = div_start_q;
  assign rsp_id      = id_q;
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_q == CYC_WIDTH'(TIMEOUT_CYCLES));

  // Reset lands in CLEAR so the divider sees one local-clear cycle before first use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      div_start_q <= 1'b0;
      div_op_1    <= '0;
      div_op_2    <= '0;
      rsp_result  <= '0;
      rsp_cycles  <= '0;
      rsp_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_CLEAR: state_q <= ST_IDLE;
        ST_IDLE: begin
          if (gnt_any) begin
            div_op_1    <= req_op_1[gnt_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
            div_op_2    <= req_op_2[gnt_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
            id_q        <= gnt_idx;
            ptr_q       <= gnt_idx;
            cnt_q       <= CYC_WIDTH'(1);
            div_start_q <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A result arriving on the timeout cycle is still a valid result.
          if (div_ready) begin
            rsp_result <= OPERAND_WIDTH'(f_pack(div_sign, div_biased_exp, div_fraction));
            rsp_cycles <= cnt_q;
            rsp_err    <= 1'b0;
            state_q    <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_result <= OPERAND_WIDTH'(QNAN_32);
            rsp_cycles <= cnt_q;
            rsp_err    <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            div_start_q <= 1'b0;
            state_q     <= ST_CLEAR;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ffdiv_share_ctrl.sv
// Self-checking bench for ffdiv_share_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_ffdiv_share_ctrl;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_op_1;
  logic [N*W-1:0]   req_op_2;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [31:0]      rsp_result;
  logic [7:0]       rsp_cycles;
  logic             rsp_err;
  logic [31:0]      div_op_1;
  logic [31:0]      div_op_2;
  logic             div_start;
  logic             div_clr_n;
  logic             div_sign;
  logic [7:0]       div_biased_exp;
  logic [22:0]      div_fraction;
  logic             div_ready;
  logic [4:0]       div_count;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  int          lat;
  bit          hang;
  int          scnt;
  logic [31:0] stub_q;
  logic        div_rst_n;

  int n_checks;
  int n_fail;
  int last_g;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    bit          hang;
    logic [31:0] exp_res;
    int          exp_cyc;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  for (genvar i = 0; i < N; i++) begin : g_ops
    assign req_op_1[i*W +: W] = op_a[i];
    assign req_op_2[i*W +: W] = op_b[i];
  end

  ffdiv_share_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_op_1       (req_op_1),
    .req_op_2       (req_op_2),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_result     (rsp_result),
    .rsp_cycles     (rsp_cycles),
    .rsp_err        (rsp_err),
    .div_op_1       (div_op_1),
    .div_op_2       (div_op_2),
    .div_start      (div_start),
    .div_clr_n      (div_clr_n),
    .div_sign       (div_sign),
    .div_biased_exp (div_biased_exp),
    .div_fraction   (div_fraction),
    .div_ready      (div_ready),
    .div_count      (div_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: known quotients for directed pairs, a scrambled value otherwise.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h3F00_0000;
    if (a == 32'h40C0_0000 && b == 32'h4040_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  assign div_rst_n = rst_n & div_clr_n;
  always @(posedge clk or negedge div_rst_n) begin
    if (!div_rst_n)     scnt <= 0;
    else if (div_start) scnt <= scnt + 1;
    else                scnt <= 0;
  end
  assign div_ready = div_start && !hang && (scnt + 1 >= lat);
  assign stub_q    = quot(div_op_1, div_op_2);
  assign {div_sign, div_biased_exp, div_fraction} = stub_q;
  assign div_count = 5'd0;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] m;
    for (int i = 1; i <= N; i++) begin
      m = v >> ((last + i) % N);
      if (m[0]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (req_ready != '0) begin
        check("grant_onehot", 64'($countones(req_ready)), 64'd1);
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) fail_bound("grant_wait");
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) fail_bound("rsp_wait");
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int g;
    bit ok;
    op_a[v.req] = v.a;
    op_b[v.req] = v.b;
    lat         = v.lat;
    hang        = v.hang;
    req_valid   = N'(1) << v.req;
    wait_grant(g);
    if (g < 0) return;
    check("vec_grant", 64'(g), 64'(v.req));
    last_g = g;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("vec_div_op_1", 64'(div_op_1), 64'(v.a));
    check("vec_div_op_2", 64'(div_op_2), 64'(v.b));
    check("vec_div_start", 64'(div_start), 64'd1);
    wait_rsp(ok);
    if (!ok) return;
    check("vec_rsp_id", 64'(rsp_id), 64'(v.req));
    check("vec_rsp_result", 64'(rsp_result), 64'(v.exp_res));
    check("vec_rsp_cycles", 64'(rsp_cycles), 64'(v.exp_cyc));
    check("vec_rsp_err", 64'(rsp_err), 64'(v.exp_err));
    accept();
    check("vec_rsp_drop", 64'(rsp_valid), 64'd0);
    check("vec_clr_low", 64'(div_clr_n), 64'd0);
    check("vec_start_low", 64'(div_start), 64'd0);
    @(negedge clk);
    #1;
    check("vec_clr_high", 64'(div_clr_n), 64'd1);
  endtask

  // Serve whichever requester the round-robin rule should pick next.
  task automatic serve_one(input bit clear_bit, output int g);
    int e;
    bit ok;
    e = rr_pick(req_valid, last_g);
    wait_grant(g);
    if (g < 0) return;
    check("serve_grant", 64'(g), 64'(e));
    last_g = g;
    @(negedge clk);
    if (clear_bit) req_valid = req_valid & ~(N'(1) << g);
    #1;
    wait_rsp(ok);
    if (!ok) return;
    check("serve_rsp_id", 64'(rsp_id), 64'(g));
    check("serve_rsp_result", 64'(rsp_result), 64'(quot(op_a[g], op_b[g])));
    check("serve_rsp_cycles", 64'(rsp_cycles), 64'(lat));
    check("serve_rsp_err", 64'(rsp_err), 64'd0);
    accept();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          g;
    int          e;
    int          hist [$];
    int          dup;
    bit          ok;
    logic [N-1:0] drop;
    logic [31:0] exp_bp;
    exp_t        x;

    n_checks  = 0;
    n_fail    = 0;
    last_g    = N - 1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    lat       = 4;
    hang      = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 5,  1'b0, 32'h3F00_0000, 5,  1'b0};
    vecs[1] = '{2, 32'h40C0_0000, 32'h4040_0000, 7,  1'b0, 32'h4000_0000, 7,  1'b0};
    vecs[2] = '{1, 32'h3F80_0000, 32'h4000_0000, 1,  1'b0, 32'h3F00_0000, 1,  1'b0};
    vecs[3] = '{3, 32'h40C0_0000, 32'h4040_0000, 4,  1'b1, 32'h7FC0_0000, 64, 1'b1};
    vecs[4] = '{0, 32'h3F80_0000, 32'h4000_0000, 64, 1'b0, 32'h3F00_0000, 64, 1'b0};
    vecs[5] = '{2, 32'h40C0_0000, 32'h4040_0000, 63, 1'b0, 32'h4000_0000, 63, 1'b0};

    #3;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_div_clr_n", 64'(div_clr_n), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_clear", 64'(div_clr_n), 64'd0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Backpressure: result held, no grant, start held; next grant 2 cycles after accept.
    op_a[1] = 32'h4120_0000; op_b[1] = 32'h4080_0000;
    op_a[3] = 32'h4248_0000; op_b[3] = 32'h3FC0_0000;
    lat = 6;
    hang = 1'b0;
    exp_bp = quot(op_a[1], op_b[1]);
    req_valid = 4'b0010;
    wait_grant(g);
    check("bp_grant", 64'(g), 64'd1);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    wait_rsp(ok);
    for (int h = 0; h < 10; h++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_result", 64'(rsp_result), 64'(exp_bp));
      check("bp_cycles", 64'(rsp_cycles), 64'd6);
      check("bp_no_grant", 64'(req_ready), 64'd0);
      check("bp_start_held", 64'(div_start), 64'd1);
      @(negedge clk);
      #1;
    end
    accept();
    check("bp_drop", 64'(rsp_valid), 64'd0);
    check("bp_clear_no_grant", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("bp_grant_2cyc", 64'(req_ready), 64'b1000);
    last_g = 3;
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(ok);
    check("bp2_result", 64'(rsp_result), 64'(quot(op_a[3], op_b[3])));
    check("bp2_id", 64'(rsp_id), 64'd3);
    accept();

    // Fairness with every requester held valid.
    for (int i = 0; i < N; i++) begin
      op_a[i] = 32'h3F80_0000 + 32'(i * 32'h0010_0000);
      op_b[i] = 32'h4000_0000 + 32'(i);
    end
    lat = 3;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      serve_one(1'b0, g);
      hist.push_back(g);
      if (hist.size() >= 4) begin
        dup = 0;
        for (int a = hist.size() - 4; a < hist.size(); a++)
          for (int b = a + 1; b < hist.size(); b++)
            if (hist[a] == hist[b]) dup++;
        check("fair_window", 64'(dup), 64'd0);
      end
    end
    req_valid = '0;

    // Reset five cycles into BUSY; pending requests restart from requester 0 priority.
    lat = 20;
    req_valid = 4'b0100;
    wait_grant(g);
    check("rstb_grant", 64'(g), 64'(rr_pick(4'b0100, last_g)));
    @(negedge clk);
    req_valid = 4'b1110;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstb_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstb_div_start", 64'(div_start), 64'd0);
    check("rstb_div_clr_n", 64'(div_clr_n), 64'd0);
    check("rstb_req_ready", 64'(req_ready), 64'd0);
    check("rstb_div_op_1", 64'(div_op_1), 64'd0);
    last_g = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 2;
    #1;
    check("rstb_rel_clr", 64'(div_clr_n), 64'd0);
    serve_one(1'b1, g);
    check("rstb_first_grant", 64'(g), 64'd1);
    serve_one(1'b1, g);
    serve_one(1'b1, g);

    // Randomized traffic against the scoreboard model.
    req_valid = '0;
    drop = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~drop;
      drop = '0;
      if (c >= 2500 && req_valid == '0 && sb.size() == 0) break;
      if (c < 2500) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
            req_valid = req_valid | (N'(1) << i);
          end
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (req_ready != '0) begin
        e = rr_pick(req_valid, last_g);
        check("rnd_grant", 64'(req_ready), 64'(N'(1) << e));
        if (e >= 0) begin
          lat = $urandom_range(1, 12);
          x.id  = e;
          x.res = quot(op_a[e], op_b[e]);
          x.cyc = lat;
          sb.push_back(x);
          last_g = e;
          drop = N'(1) << e;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          fail_bound("rnd_unexpected_rsp");
        end else begin
          x = sb.pop_front();
          check("rnd_rsp_id", 64'(rsp_id), 64'(x.id));
          check("rnd_rsp_result", 64'(rsp_result), 64'(x.res));
          check("rnd_rsp_cycles", 64'(rsp_cycles), 64'(x.cyc));
          check("rnd_rsp_err", 64'(rsp_err), 64'd0);
        end
      end
    end
    rsp_ready = 1'b0;
    check("rnd_drain", 64'({req_valid, 32'(sb.size())}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
